// File: rtl/mac_row_dual_if.sv
// Signal bundle for one mac_row_dual row.
// Carries the west/north operands, the mode request and the south/east results and status.
interface mac_row_dual_if #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int col     = 8
);
   logic                   mode;
   logic [bw-1:0]          in_w;
   logic [1:0]             inst_w;
   logic [psum_bw*col-1:0] in_n;
   logic [psum_bw*col-1:0] out_s;
   logic [col-1:0]         valid;
   logic [bw-1:0]          out_e;
   logic [1:0]             inst_e;
   logic                   mode_q;
   logic                   busy;

   modport master (
      output mode, in_w, inst_w, in_n,
      input  out_s, valid, out_e, inst_e, mode_q, busy
   );

   modport slave (
      input  mode, in_w, inst_w, in_n,
      output out_s, valid, out_e, inst_e, mode_q, busy
   );
endinterface

// File: rtl/mac_row_dual.sv
// One row of a dual-mode systolic MAC array: weight-stationary (psum flows north->south)
// or output-stationary (accumulate in place, drained by flush). Activations travel west->east.
module mac_row_dual #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int col     = 8,
   parameter bit SIGNED  = 1'b1
) (
   input logic           clk,
   input logic           reset,
   mac_row_dual_if.slave bus
);

   typedef enum logic [1:0] {
      INST_IDLE  = 2'b00,
      INST_LOAD  = 2'b01,
      INST_EXEC  = 2'b10,
      INST_FLUSH = 2'b11
   } inst_t;

   typedef enum logic {
      MODE_WS = 1'b0,
      MODE_OS = 1'b1
   } mode_t;

   typedef logic [psum_bw-1:0] psum_t;

   logic [col-1:0][bw-1:0] a_q, a_d, a_in;
   logic [col-1:0][bw-1:0] w_q, w_d;
   logic [col-1:0][1:0]    inst_q, inst_d, inst_in;
   psum_t [col-1:0]        acc_q, acc_d;
   psum_t [col-1:0]        out_s_q, out_s_d;
   psum_t [col-1:0]        in_n_v;
   logic [col-1:0]         valid_q, valid_d;
   mode_t                  mode_q, mode_d;
   logic                   busy;
   logic                   load_now;

   // bw x bw product, then sign- or zero-extended to the accumulator width.
   function automatic psum_t prod_ext(input logic [bw-1:0] a, input logic [bw-1:0] b);
      logic [2*bw-1:0] p;
      logic            ext;
      if (SIGNED) begin
         p   = $signed({{bw{a[bw-1]}}, a}) * $signed({{bw{b[bw-1]}}, b});
         ext = p[2*bw-1];
      end else begin
         p   = {{bw{1'b0}}, a} * {{bw{1'b0}}, b};
         ext = 1'b0;
      end
      return {{(psum_bw-2*bw){ext}}, p};
   endfunction

   assign in_n_v   = bus.in_n;
   assign load_now = (bus.inst_w == INST_LOAD) && (mode_q == MODE_WS);

   always_comb begin
      a_in[0]    = bus.in_w;
      inst_in[0] = bus.inst_w;
      for (int i = 1; i < col; i++) begin
         a_in[i]    = a_q[i-1];
         inst_in[i] = inst_q[i-1];
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < col; i++) begin
         busy = busy | (inst_q[i] != INST_IDLE);
      end
   end

   always_comb begin
      // NOTE: every *_d gets a default before any branch, so no path can leave one unassigned and infer a latch.
      a_d     = a_in;
      inst_d  = inst_in;
      w_d     = w_q;
      acc_d   = acc_q;
      out_s_d = out_s_q;
      valid_d = '0;
      mode_d  = mode_q;

      // Mode only changes on a quiet row so no token ever sees two modes.
      if (!busy && bus.inst_w == INST_IDLE) begin
         mode_d = mode_t'(bus.mode);
      end

      if (load_now) begin
         w_d[0] = bus.in_w;
         for (int i = 1; i < col; i++) begin
            w_d[i] = w_q[i-1];
         end
      end

      for (int i = 0; i < col; i++) begin
         case (inst_in[i])
            INST_EXEC: begin
               if (mode_q == MODE_WS) begin
                  out_s_d[i] = in_n_v[i] + prod_ext(a_in[i], w_q[i]);
                  valid_d[i] = 1'b1;
               end else begin
                  acc_d[i] = acc_q[i] + prod_ext(a_in[i], in_n_v[i][bw-1:0]);
               end
            end
            INST_FLUSH: begin
               if (mode_q == MODE_OS) begin
                  out_s_d[i] = acc_q[i];
                  valid_d[i] = 1'b1;
                  acc_d[i]   = '0;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: weights and accumulators are plain flops, so clearing them on reset is cheap and leaves a known row.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q     <= '0;
         inst_q  <= '0;
         w_q     <= '0;
         acc_q   <= '0;
         out_s_q <= '0;
         valid_q <= '0;
         mode_q  <= MODE_WS;
      end else begin
         // NOTE: non-blocking so every column samples its neighbour's pre-edge value.
         a_q     <= a_d;
         inst_q  <= inst_d;
         w_q     <= w_d;
         acc_q   <= acc_d;
         out_s_q <= out_s_d;
         valid_q <= valid_d;
         mode_q  <= mode_d;
      end
   end

   assign bus.out_s  = out_s_q;
   assign bus.valid  = valid_q;
   assign bus.out_e  = a_q[col-1];
   assign bus.inst_e = inst_q[col-1];
   assign bus.mode_q = mode_q;
   assign bus.busy   = busy;

endmodule

// File: tb/tb_mac_row_dual.sv
// Scoreboard bench for mac_row_dual: each test plans a stream, derives expected column
// outputs and arrival cycles from a per-token reference, and a negedge monitor consumes them.
module tb_mac_row_dual;
   localparam int BW   = 4;
   localparam int PB   = 16;
   localparam int COL  = 8;
   localparam int MAXL = 80;

   localparam logic [1:0] I_IDLE  = 2'b00;
   localparam logic [1:0] I_LOAD  = 2'b01;
   localparam logic [1:0] I_EXEC  = 2'b10;
   localparam logic [1:0] I_FLUSH = 2'b11;

   typedef struct {
      logic [1:0]    inst;
      logic [BW-1:0] a;
      logic          mode;
   } step_t;

   typedef struct {
      logic [PB-1:0] val;
      int            cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   mon_en = 1'b0;
   bit   chk_u  = 1'b0;

   exp_t exp_q[COL][$];
   exp_t exp_u[$];

   logic [BW-1:0]          w_m   [COL];
   logic [PB-1:0]          acc_m [COL];
   logic                   mode_m;
   logic [COL-1:0][PB-1:0] n_vec;

   mac_row_dual_if #(.bw(BW), .psum_bw(PB), .col(COL)) bus ();
   mac_row_dual_if #(.bw(BW), .psum_bw(PB), .col(1))   bus_u ();

   mac_row_dual #(.bw(BW), .psum_bw(PB), .col(COL), .SIGNED(1'b1)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Single-column unsigned row sharing the west inputs, used for the unsigned product case.
   mac_row_dual #(.bw(BW), .psum_bw(PB), .col(1), .SIGNED(1'b0)) u_dut_u (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_u.slave)
   );

   assign bus_u.mode   = bus.mode;
   assign bus_u.in_w   = bus.in_w;
   assign bus_u.inst_w = bus.inst_w;
   assign bus_u.in_n   = bus.in_n[PB-1:0];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [PB-1:0] pm(input logic [BW-1:0] a, input logic [BW-1:0] b, input bit sgn);
      int x, y;
      x = int'(a);
      y = int'(b);
      if (sgn && a[BW-1]) x = x - (1 << BW);
      if (sgn && b[BW-1]) y = y - (1 << BW);
      return PB'(x * y);
   endfunction

   function automatic step_t mk(input logic [1:0] inst, input logic [BW-1:0] a, input logic m);
      step_t s;
      s.inst = inst;
      s.a    = a;
      s.mode = m;
      return s;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (mon_en && !reset) begin
         for (int i = 0; i < COL; i++) begin
            if (exp_q[i].size() > 0 && exp_q[i][0].cyc == cyc) begin
               e = exp_q[i].pop_front();
               total++;
               if (bus.valid[i] !== 1'b1 || bus.out_s[i*PB +: PB] !== e.val) begin
                  bad++;
                  $display("FAIL out_col%0d cyc=%0d: got valid=%b out_s=%h, want valid=1 out_s=%h",
                           i, cyc, bus.valid[i], bus.out_s[i*PB +: PB], e.val);
               end
            end else if (bus.valid[i] !== 1'b0) begin
               total++;
               bad++;
               $display("FAIL stray_valid_col%0d cyc=%0d: got valid=%b out_s=%h, want valid=0",
                        i, cyc, bus.valid[i], bus.out_s[i*PB +: PB]);
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (chk_u && !reset) begin
         if (exp_u.size() > 0 && exp_u[0].cyc == cyc) begin
            e = exp_u.pop_front();
            total++;
            if (bus_u.valid[0] !== 1'b1 || bus_u.out_s !== e.val) begin
               bad++;
               $display("FAIL unsigned_out cyc=%0d: got valid=%b out_s=%h, want valid=1 out_s=%h",
                        cyc, bus_u.valid[0], bus_u.out_s, e.val);
            end
         end else if (bus_u.valid[0] !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL unsigned_stray cyc=%0d: got valid=%b, want 0", cyc, bus_u.valid[0]);
         end
      end
   end

   // Plans a stream from a quiet row, pushes expected results, drives it and checks control/east outputs.
   task automatic run_plan(input step_t plan[$]);
      step_t         p[$];
      logic [BW-1:0] wh [MAXL+1][COL];
      logic          me [MAXL+1];
      logic          bz [MAXL];
      logic          tail_mode;
      logic [BW-1:0] want_a;
      logic [1:0]    want_i;
      exp_t          e;
      int            len, c0;

      p = plan;
      tail_mode = (plan.size() > 0) ? plan[plan.size()-1].mode : mode_m;
      for (int k = 0; k < COL + 2; k++) p.push_back(mk(I_IDLE, '0, tail_mode));
      len = p.size();
      if (len > MAXL) begin
         $display("FAIL plan_length: got %0d, limit %0d", len, MAXL);
         $fatal(1, "plan too long");
      end

      for (int j = 0; j < COL; j++) wh[0][j] = w_m[j];
      me[0] = mode_m;
      for (int t = 0; t < len; t++) begin
         bz[t] = 1'b0;
         for (int j = 1; j <= COL; j++) begin
            if (t - j >= 0) begin
               if (p[t-j].inst != I_IDLE) bz[t] = 1'b1;
            end
         end
         me[t+1] = (!bz[t] && p[t].inst == I_IDLE) ? p[t].mode : me[t];
         for (int j = 0; j < COL; j++) wh[t+1][j] = wh[t][j];
         if (p[t].inst == I_LOAD && me[t] == 1'b0) begin
            wh[t+1][0] = p[t].a;
            for (int j = 1; j < COL; j++) wh[t+1][j] = wh[t][j-1];
         end
      end

      // A token driven in cycle t is handled by column i at the edge ending cycle t+i.
      c0 = cyc + 1;
      for (int i = 0; i < COL; i++) begin
         for (int t = 0; t + i < len; t++) begin
            if (p[t].inst == I_EXEC && me[t+i] == 1'b0) begin
               e.val = n_vec[i] + pm(p[t].a, wh[t+i][i], 1'b1);
               e.cyc = c0 + t + i + 1;
               exp_q[i].push_back(e);
            end else if (p[t].inst == I_EXEC && me[t+i] == 1'b1) begin
               acc_m[i] = acc_m[i] + pm(p[t].a, n_vec[i][BW-1:0], 1'b1);
            end else if (p[t].inst == I_FLUSH && me[t+i] == 1'b1) begin
               e.val = acc_m[i];
               e.cyc = c0 + t + i + 1;
               exp_q[i].push_back(e);
               acc_m[i] = '0;
            end
         end
      end

      for (int t = 0; t < len; t++) begin
         @(posedge clk);
         #1;
         bus.inst_w = p[t].inst;
         bus.in_w   = p[t].a;
         bus.mode   = p[t].mode;
         bus.in_n   = n_vec;
         @(negedge clk);
         total++;
         if (bus.mode_q !== me[t] || bus.busy !== bz[t]) begin
            bad++;
            $display("FAIL ctrl cyc=%0d: got mode_q=%b busy=%b, want mode_q=%b busy=%b",
                     cyc, bus.mode_q, bus.busy, me[t], bz[t]);
         end
         want_a = '0;
         want_i = I_IDLE;
         if (t >= COL) begin
            want_a = p[t-COL].a;
            want_i = p[t-COL].inst;
         end
         total++;
         if (bus.out_e !== want_a || bus.inst_e !== want_i) begin
            bad++;
            $display("FAIL east cyc=%0d: got out_e=%h inst_e=%b, want out_e=%h inst_e=%b",
                     cyc, bus.out_e, bus.inst_e, want_a, want_i);
         end
      end

      mode_m = me[len];
      for (int j = 0; j < COL; j++) w_m[j] = wh[len][j];
      for (int i = 0; i < COL; i++) begin
         total++;
         if (exp_q[i].size() != 0) begin
            bad++;
            $display("FAIL missing_col%0d: got %0d results pending, want 0", i, exp_q[i].size());
            exp_q[i].delete();
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if (bus.valid !== '0 || bus.out_s !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got valid=%h out_s=%h, want 0", bus.valid, bus.out_s);
      end
      total++;
      if (bus.mode_q !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got mode_q=%b busy=%b, want 0 0", bus.mode_q, bus.busy);
      end
      total++;
      if (bus.out_e !== '0 || bus.inst_e !== 2'b00) begin
         bad++;
         $display("FAIL reset_east: got out_e=%h inst_e=%b, want 0", bus.out_e, bus.inst_e);
      end
      @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_ws_load_exec();
      step_t pl[$];
      for (int i = 0; i < COL; i++) n_vec[i] = 16'd5;
      for (int k = 1; k <= COL; k++) pl.push_back(mk(I_LOAD, BW'(k), 1'b0));
      pl.push_back(mk(I_EXEC, 4'd3, 1'b0));
      pl.push_back(mk(I_EXEC, 4'hE, 1'b0));
      pl.push_back(mk(I_EXEC, 4'd7, 1'b0));
      run_plan(pl);
   endtask

   task automatic test_os_flush();
      step_t pl[$];
      for (int i = 0; i < COL; i++) n_vec[i] = PB'(i + 1);
      pl.push_back(mk(I_IDLE, '0, 1'b1));
      for (int k = 0; k < 4; k++) pl.push_back(mk(I_EXEC, 4'd2, 1'b1));
      pl.push_back(mk(I_FLUSH, '0, 1'b1));
      pl.push_back(mk(I_IDLE, '0, 1'b1));
      pl.push_back(mk(I_FLUSH, '0, 1'b1));
      run_plan(pl);
   endtask

   task automatic test_wrap();
      step_t pl[$];
      exp_t  e;
      int    c0;
      for (int i = 0; i < COL; i++) n_vec[i] = 16'h7FE0;
      pl.push_back(mk(I_IDLE, '0, 1'b0));
      pl.push_back(mk(I_LOAD, 4'b1000, 1'b0));
      pl.push_back(mk(I_EXEC, 4'b1000, 1'b0));
      pl.push_back(mk(I_LOAD, 4'd2, 1'b0));
      pl.push_back(mk(I_EXEC, 4'hF, 1'b0));
      c0 = cyc + 1;
      e.val = 16'h7FE0 + pm(4'b1000, 4'b1000, 1'b0);
      e.cyc = c0 + 3;
      exp_u.push_back(e);
      e.val = 16'h7FE0 + pm(4'hF, 4'd2, 1'b0);
      e.cyc = c0 + 5;
      exp_u.push_back(e);
      chk_u = 1'b1;
      run_plan(pl);
      chk_u = 1'b0;
      total++;
      if (exp_u.size() != 0) begin
         bad++;
         $display("FAIL unsigned_missing: got %0d pending, want 0", exp_u.size());
         exp_u.delete();
      end
   endtask

   task automatic test_mode_defer();
      step_t pl[$];
      for (int i = 0; i < COL; i++) n_vec[i] = PB'(3 * i + 1);
      for (int k = 0; k < 8; k++) pl.push_back(mk(I_EXEC, BW'(k + 1), (k == 0) ? 1'b0 : 1'b1));
      for (int k = 0; k < COL + 2; k++) pl.push_back(mk(I_IDLE, '0, 1'b1));
      pl.push_back(mk(I_EXEC, 4'd3, 1'b1));
      pl.push_back(mk(I_FLUSH, '0, 1'b1));
      run_plan(pl);
      total++;
      if (bus.mode_q !== 1'b1) begin
         bad++;
         $display("FAIL mode_after_defer: got %b, want 1", bus.mode_q);
      end
   endtask

   task automatic test_load_overlap();
      step_t pl[$];
      for (int i = 0; i < COL; i++) n_vec[i] = '0;
      pl.push_back(mk(I_IDLE, '0, 1'b0));
      pl.push_back(mk(I_EXEC, 4'd1, 1'b0));
      pl.push_back(mk(I_LOAD, 4'd6, 1'b0));
      pl.push_back(mk(I_EXEC, 4'd1, 1'b0));
      run_plan(pl);
   endtask

   task automatic test_back_to_back();
      step_t pl[$];
      for (int i = 0; i < COL; i++) n_vec[i] = PB'($urandom);
      pl.push_back(mk(I_IDLE, '0, 1'b0));
      for (int k = 0; k < COL; k++) pl.push_back(mk(I_LOAD, BW'($urandom), 1'b0));
      for (int k = 0; k < 12; k++) pl.push_back(mk(I_EXEC, BW'($urandom), 1'b0));
      run_plan(pl);
   endtask

   task automatic test_reset_mid();
      step_t pl[$];
      for (int i = 0; i < COL; i++) n_vec[i] = PB'(i + 1);
      pl.push_back(mk(I_IDLE, '0, 1'b1));
      for (int k = 0; k < 3; k++) pl.push_back(mk(I_EXEC, 4'd2, 1'b1));
      run_plan(pl);

      mon_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         bus.inst_w = I_FLUSH;
         bus.in_w   = 4'd9;
         bus.mode   = 1'b1;
      end
      @(posedge clk);
      #1;
      reset       = 1'b1;
      bus.inst_w  = I_IDLE;
      bus.in_w    = '0;
      bus.mode    = 1'b0;
      #1;
      total++;
      if (bus.valid !== '0 || bus.out_s !== '0) begin
         bad++;
         $display("FAIL midreset_outputs: got valid=%h out_s=%h, want 0", bus.valid, bus.out_s);
      end
      total++;
      if (bus.busy !== 1'b0 || bus.mode_q !== 1'b0) begin
         bad++;
         $display("FAIL midreset_ctrl: got busy=%b mode_q=%b, want 0 0", bus.busy, bus.mode_q);
      end
      for (int i = 0; i < COL; i++) begin
         exp_q[i].delete();
         w_m[i]   = '0;
         acc_m[i] = '0;
      end
      mode_m = 1'b0;
      @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;

      pl.delete();
      for (int i = 0; i < COL; i++) n_vec[i] = 16'h1234;
      pl.push_back(mk(I_EXEC, 4'd5, 1'b0));
      pl.push_back(mk(I_EXEC, 4'hB, 1'b0));
      run_plan(pl);
   endtask

   initial begin
      bus.mode   = 1'b0;
      bus.in_w   = '0;
      bus.inst_w = I_IDLE;
      bus.in_n   = '0;
      mode_m     = 1'b0;
      for (int i = 0; i < COL; i++) begin
         w_m[i]   = '0;
         acc_m[i] = '0;
         n_vec[i] = '0;
      end
      test_reset();
      test_ws_load_exec();
      test_os_flush();
      test_wrap();
      test_mode_defer();
      test_load_overlap();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
